fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 98 +++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage with PC, IF/ID register and fetch counter.
// Redirects (branch, jump) take priority over stall and memory wait.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall,
  input  logic        Branch,
  input  logic [31:0] BranchTarget,
  input  logic        JUMPSrc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        imem_ready,
  output logic [31:0] ins,
  output logic [31:0] pc_plus4,
  output logic        ins_valid,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ins_q, ins_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] jump_tgt;
  logic [31:0] pc_inc;

  assign imem_addr   = pc_q;
  assign ins         = ins_q;
  assign pc_plus4    = pc4_q;
  assign ins_valid   = valid_q;
  assign fetch_count = cnt_q;

  assign jump_tgt = {pc4_q[31:28], ins_q[25:0], 2'b00};
  assign pc_inc   = pc_q + 32'd4;

  // Next-state: redirects flush IF/ID, stall freezes, miss inserts a bubble.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ins_d   = ins_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (Branch) begin
      pc_d    = BranchTarget;
      ins_d   = NOP_WORD;
      valid_d = 1'b0;
      state_d = RUN;
    end else if (JUMPSrc) begin
      pc_d    = jump_tgt;
      ins_d   = NOP_WORD;
      valid_d = 1'b0;
      state_d = RUN;
    end else if (Stall) begin
      state_d = state_q;
    end else if (!imem_ready) begin
      ins_d   = NOP_WORD;
      valid_d = 1'b0;
      state_d = WAIT;
    end else begin
      ins_d   = imem_data;
      pc4_d   = pc_inc;
      valid_d = 1'b1;
      pc_d    = pc_inc;
      cnt_d   = cnt_q + 32'd1;
      state_d = RUN;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      ins_q   <= NOP_WORD;
      pc4_q   <= RESET_PC + 32'd4;
      valid_q <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ins_q   <= ins_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
